vga_grid_scan: RTL

- Pixel-timing front end for the board display. Generates 640x480@60 VGA sync plus the CounterX/CounterY beam position consumed by the pixel colouring stage.
- Also decodes the 8x8 play-field window, 20 px cells with origin (200,200), into cell_idx. The colour stage indexes its 64-bit block/next vectors directly with cell_idx; no division is needed downstream.

---
 rtl/vga_grid_scan.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/vga_grid_scan.sv
// 640x480@60 VGA timing with beam position and 8x8 play-field cell decode.
// Define GRID_LINES_EN to build the grid_line outline output.
module vga_grid_scan #(
    parameter int CLK_DIV = 2,
    parameter int H_VIS   = 640,
    parameter int H_FP    = 16,
    parameter int H_SYNC  = 96,
    parameter int H_BP    = 48,
    parameter int V_VIS   = 480,
    parameter int V_FP    = 10,
    parameter int V_SYNC  = 2,
    parameter int V_BP    = 33,
    parameter int GRID_X0 = 200,
    parameter int GRID_Y0 = 200,
    parameter int CELL    = 20,
    parameter int GRID_N  = 8
) (
    input  logic       clk,
    input  logic       rst,
    output logic [9:0] CounterX,
    output logic [9:0] CounterY,
    output logic       vga_h_sync,
    output logic       vga_v_sync,
    output logic       inDisplayArea,
    output logic       pix_tick,
    output logic       in_grid,
    output logic [5:0] cell_idx,
    output logic       frame_tick,
    output logic       grid_line
);
    localparam int H_TOTAL  = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int HS_START = H_VIS + H_FP;
    localparam int HS_END   = HS_START + H_SYNC;
    localparam int VS_START = V_VIS + V_FP;
    localparam int VS_END   = VS_START + V_SYNC;
    localparam int X_END    = GRID_X0 + GRID_N * CELL;
    localparam int Y_END    = GRID_Y0 + GRID_N * CELL;
    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int PW = (CELL > 1) ? $clog2(CELL) : 1;
    localparam int CW = (GRID_N > 1) ? $clog2(GRID_N) : 1;

    generate
        if (X_END > H_VIS) begin : g_chk_x
            $error("grid extends past H_VIS");
        end
        if (Y_END > V_VIS) begin : g_chk_y
            $error("grid extends past V_VIS");
        end
        if ((1 << CW) != GRID_N || 2 * CW > 6) begin : g_chk_n
            $error("GRID_N must be a power of two with GRID_N*GRID_N <= 64");
        end
    endgenerate

    logic [DW-1:0] div_cnt;
    logic          running;
    logic [PW-1:0] px_in_cell, py_in_cell;
    logic [CW-1:0] col, row;
    logic          gx_act, gy_act;
    logic          line_end;
    logic [9:0]    nx, ny;

    // running keeps pix_tick low during reset even when CLK_DIV==1
    assign pix_tick = running && (div_cnt == DW'(CLK_DIV - 1));
    assign line_end = (CounterX == 10'(H_TOTAL - 1));

    always_comb begin
        nx = CounterX + 10'd1;
        ny = CounterY;
        if (line_end) begin
            nx = 10'd0;
            ny = (CounterY == 10'(V_TOTAL - 1)) ? 10'd0 : CounterY + 10'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt       <= '0;
            running       <= 1'b0;
            CounterX      <= 10'd0;
            CounterY      <= 10'd0;
            vga_h_sync    <= 1'b1;
            vga_v_sync    <= 1'b1;
            inDisplayArea <= 1'b1;
            frame_tick    <= 1'b0;
            px_in_cell    <= '0;
            col           <= '0;
            gx_act        <= 1'b0;
            py_in_cell    <= '0;
            row           <= '0;
            gy_act        <= 1'b0;
        end else begin
            running    <= 1'b1;
            div_cnt    <= (div_cnt == DW'(CLK_DIV - 1)) ? '0 : div_cnt + 1'b1;
            frame_tick <= 1'b0;
            if (pix_tick) begin
                CounterX      <= nx;
                CounterY      <= ny;
                vga_h_sync    <= !(nx >= 10'(HS_START) && nx < 10'(HS_END));
                vga_v_sync    <= !(ny >= 10'(VS_START) && ny < 10'(VS_END));
                inDisplayArea <= (nx < 10'(H_VIS)) && (ny < 10'(V_VIS));
                frame_tick    <= (nx == 10'd0) && (ny == 10'(V_VIS));

                // column sub-counters follow the pixel that X is about to show
                if (nx == 10'(GRID_X0)) begin
                    px_in_cell <= '0;
                    col        <= '0;
                    gx_act     <= 1'b1;
                end else if (line_end) begin
                    px_in_cell <= '0;
                    col        <= '0;
                    gx_act     <= 1'b0;
                end else if (gx_act) begin
                    if (px_in_cell == PW'(CELL - 1)) begin
                        px_in_cell <= '0;
                        if (col == CW'(GRID_N - 1)) gx_act <= 1'b0;
                        else                        col    <= col + 1'b1;
                    end else begin
                        px_in_cell <= px_in_cell + 1'b1;
                    end
                end

                if (line_end) begin
                    if (ny == 10'(GRID_Y0)) begin
                        py_in_cell <= '0;
                        row        <= '0;
                        gy_act     <= 1'b1;
                    end else if (ny == 10'd0) begin
                        py_in_cell <= '0;
                        row        <= '0;
                        gy_act     <= 1'b0;
                    end else if (gy_act) begin
                        if (py_in_cell == PW'(CELL - 1)) begin
                            py_in_cell <= '0;
                            if (row == CW'(GRID_N - 1)) gy_act <= 1'b0;
                            else                        row    <= row + 1'b1;
                        end else begin
                            py_in_cell <= py_in_cell + 1'b1;
                        end
                    end
                end
            end
        end
    end

    assign in_grid  = gx_act && gy_act;
    assign cell_idx = in_grid ? 6'({row, col}) : 6'd0;

`ifdef GRID_LINES_EN
    logic x_close, y_close;
    assign x_close   = (CounterX == 10'(X_END));
    assign y_close   = (CounterY == 10'(Y_END));
    // closing edges include the bottom-right corner so the outline is shut
    assign grid_line = (in_grid && (px_in_cell == '0 || py_in_cell == '0))
                     || (x_close && (gy_act || y_close))
                     || (y_close && (gx_act || x_close));
`else
    assign grid_line = 1'b0;
`endif

endmodule
